jam_cost_arbiter: RTL
=====================

Name: jam_cost_arbiter

Overview:
- Shares one Cost ROM port (W/J address, Cost data) among N_REQ permutation-search engines.
- An engine submits a full 8-worker permutation. The block grants the port round-robin, issues the 8 worker/job lookups, accumulates the total cost and returns it to that engine.
- Sits between the engine array and the single cost-table interface.

Parameters:
- N_REQ, 4, number of requesting engines (2..8).
- COST_LAT, 1, cycles from W/J presented to Cost valid (0..3).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- req  in  N_REQ  per-engine request level
- req_perm  in  N_REQ*24  per-engine permutation; slice i holds 8 x 3-bit jobs, job of worker k at bits [i*24+3k +: 3]
- gnt  out  N_REQ  one-hot burst owner
- rsp_valid  out  N_REQ  one-hot 1-cycle result pulse to owner
- rsp_sum  out  10  total cost of owner's permutation; valid with rsp_valid
- busy  out  1  burst in progress
- W  out  3  worker index to cost ROM
- J  out  3  job index to cost ROM
- Cost  in  7  cost ROM data
- stat_gnt_cnt  out  N_REQ*16  grant counters (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high RST; clock CLK.
  - state=IDLE; all outputs 0; rr pointer set so requester 0 has highest priority.
  - Accumulator and counters cleared.
  - RST mid-burst aborts the burst; no rsp_valid is issued.
- States:
  - IDLE: if req!=0, arbitrate; next ISSUE.
  - ISSUE: 8 cycles, beat 0..7; next DRAIN, or DONE if COST_LAT=0.
  - DRAIN: COST_LAT cycles, then DONE.
  - DONE: 1 cycle; rsp_valid[owner]=1; next ISSUE if req!=0 (re-arbitrate), else IDLE.
- Arbitration (at IDLE->ISSUE and DONE->ISSUE edges):
  - Round-robin starting at requester (last_owner+1) mod N_REQ, wrapping.
  - last_owner updates on each grant.
  - req_perm of the winner is latched in the grant cycle; the engine may change it afterwards.
- gnt:
  - gnt[owner] is high from the first ISSUE cycle through DONE inclusive.
  - gnt is 0 in IDLE.
- ROM addressing:
  - In ISSUE, W=beat and J=perm_lat[beat] (combinational from registered beat/perm_lat).
  - Outside ISSUE, W=0 and J=0.
- Accumulation:
  - Cost is added when a beat's valid bit exits a COST_LAT-deep shift register (COST_LAT=0: same cycle).
  - Accumulator is 10-bit, cleared at each grant; max 8*127=1016, no overflow.
  - rsp_sum holds the last completed sum until the next DONE.
- Latency and throughput:
  - Grant edge to rsp_valid = 8+COST_LAT cycles.
  - Back-to-back bursts run with no idle cycle; port throughput is one permutation per 9+COST_LAT cycles.
- Request rules:
  - req is level-sensitive.
  - Owner deasserting req mid-burst does not abort the burst; result is still delivered.
  - Owner still requesting in DONE competes as a new request at lowest priority.
  - A req withdrawn before grant is simply not granted.
- Simultaneous requests: the single winner is chosen by rr order; losers wait, never starve (bounded by N_REQ-1 bursts).
- busy = (state != IDLE).

Optional Feature:
- JAM_ARB_STATS_EN defined: per-requester 16-bit grant counters, saturating at 0xFFFF.
  - Incremented on each grant to that requester; cleared by RST.
  - Driven on stat_gnt_cnt.
- Undefined: stat_gnt_cnt tied to 0 and no counter flops; the port stays present so the interface is stable.

Decomposition:
- Package jam_pkg:
  - N_WORK=8, JOB_W=3, COST_W=7, SUM_W=10.
  - State enum arb_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module jam_rr_picker: combinational round-robin one-hot pick from req and last_owner.
- The FSM, latching and accumulation stay in the top.

Test Plan:
- Single request, COST_LAT=1, ROM cost=W*10+J, req0 perm identity 0..7 -> gnt[0] for 10 cycles; W/J walk 0/0..7/7; rsp_valid[0] 9 cycles after grant edge; rsp_sum=308.
- req0..req3 all asserted continuously -> grants 0,1,2,3,0 in that order, contiguous bursts, each rsp_valid one-hot to the matching owner.
- All costs 127, perm 7..0 -> rsp_sum=1016, no wrap.
- req1 drops at beat 3 of its own burst -> burst completes, rsp_valid[1] still pulses, next grant goes to the next pending requester.
- RST asserted at beat 5 -> next cycle: gnt=0, busy=0, W=J=0, no rsp_valid; after release, req2 alone is granted first.
- COST_LAT=0 and COST_LAT=3 builds with the identity test -> sum 308; rsp_valid at 8 and 11 cycles respectively.

Source files
------------

// File: rtl/jam_cost_arbiter_pkg.sv
// Shared widths and types for the cost-ROM arbiter slice.
package jam_pkg;
   localparam int N_WORK = 8;
   localparam int JOB_W  = 3;
   localparam int COST_W = 7;
   localparam int SUM_W  = 10;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} arb_state_t;

   // job of worker k lives in element k (bits [3k +: 3])
   typedef logic [N_WORK-1:0][JOB_W-1:0] perm_t;
endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine-array and cost-ROM signals of the arbiter, grouped as one bundle.
interface jam_cost_arbiter_if
   import jam_pkg::*;
#(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]            req;
   perm_t [N_REQ-1:0]           req_perm;
   logic [N_REQ-1:0]            gnt;
   logic [N_REQ-1:0]            rsp_valid;
   logic [SUM_W-1:0]            rsp_sum;
   logic                        busy;
   logic [JOB_W-1:0]            W;
   logic [JOB_W-1:0]            J;
   logic [COST_W-1:0]           Cost;
   logic [N_REQ-1:0][CNT_W-1:0] stat_gnt_cnt;

   modport master (
      output req, req_perm, Cost,
      input  gnt, rsp_valid, rsp_sum, busy, W, J, stat_gnt_cnt
   );
   modport slave (
      input  req, req_perm, Cost,
      output gnt, rsp_valid, rsp_sum, busy, W, J, stat_gnt_cnt
   );
endinterface

// File: rtl/jam_cost_arbiter_rr_picker.sv
// Combinational round-robin pick: search starts just after last_owner, so the
// previous owner ends up with the lowest priority.
module jam_rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_owner,
   output logic [N_REQ-1:0] pick_oh,
   output logic [IDX_W-1:0] pick_idx
);
   logic found;

   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      found    = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!found && req[(int'(last_owner) + i) % N_REQ]) begin
            found = 1'b1;
            pick_oh[(int'(last_owner) + i) % N_REQ] = 1'b1;
            pick_idx = IDX_W'((int'(last_owner) + i) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin sharing of one cost-ROM port; each burst walks 8 worker/job
// lookups and returns the summed cost. JAM_ARB_STATS_EN adds grant counters.
module jam_cost_arbiter
   import jam_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int COST_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   jam_cost_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t       state;
   logic [2:0]       beat;
   logic [1:0]       drain_cnt;
   logic [IDX_W-1:0] last_owner;
   perm_t            perm_lat;
   logic [SUM_W-1:0] acc, acc_next;
   logic [N_REQ-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             issue, cost_vld, grant;

   jam_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req        (bus.req),
      .last_owner (last_owner),
      .pick_oh    (pick_oh),
      .pick_idx   (pick_idx)
   );

   assign issue = (state == ISSUE);
   assign grant = (|bus.req) && (state == IDLE || state == DONE);
   assign bus.W = issue ? beat : '0;
   assign bus.J = issue ? perm_lat[beat] : '0;

   // beat valid travels alongside the ROM latency so Cost is summed on arrival
   generate
      if (COST_LAT == 0) begin : g_lat0
         assign cost_vld = issue;
      end else begin : g_latn
         logic [COST_LAT-1:0] vld_pipe;
         always_ff @(posedge CLK) begin
            if (RST) vld_pipe <= '0;
            else     vld_pipe <= (vld_pipe << 1) | COST_LAT'(issue);
         end
         assign cost_vld = vld_pipe[COST_LAT-1];
      end
   endgenerate

   assign acc_next = acc + (cost_vld ? SUM_W'(bus.Cost) : '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         beat          <= '0;
         drain_cnt     <= '0;
         last_owner    <= IDX_W'(N_REQ - 1);
         perm_lat      <= '0;
         acc           <= '0;
         bus.gnt       <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_sum   <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.rsp_valid <= '0;
         acc           <= acc_next;
         case (state)
            IDLE: ;
            ISSUE: begin
               beat <= beat + 3'd1;
               if (beat == 3'(N_WORK - 1)) begin
                  if (COST_LAT == 0) begin
                     state         <= DONE;
                     bus.rsp_valid <= bus.gnt;
                     bus.rsp_sum   <= acc_next;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= 2'(COST_LAT - 1);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state         <= DONE;
                  bus.rsp_valid <= bus.gnt;
                  bus.rsp_sum   <= acc_next;
               end else begin
                  drain_cnt <= drain_cnt - 2'd1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // a grant overrides the DONE->IDLE fallthrough for back-to-back bursts
         if (grant) begin
            state      <= ISSUE;
            beat       <= '0;
            acc        <= '0;
            bus.gnt    <= pick_oh;
            bus.busy   <= 1'b1;
            last_owner <= pick_idx;
            perm_lat   <= bus.req_perm[pick_idx];
         end
      end
   end

`ifdef JAM_ARB_STATS_EN
   logic [N_REQ-1:0][CNT_W-1:0] gnt_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         gnt_cnt <= '0;
      end else if (grant) begin
         for (int i = 0; i < N_REQ; i++)
            if (pick_oh[i] && gnt_cnt[i] != '1) gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
      end
   end
   assign bus.stat_gnt_cnt = gnt_cnt;
`else
   assign bus.stat_gnt_cnt = '0;
`endif
endmodule
